// File: rtl/mp_dispatch_pkg.sv
// Shared constants, FSM state type and beat payload helper for the dispatch master.
package mp_dispatch_pkg;

    localparam int unsigned PID_W = 9;
    localparam int unsigned OFF_W = 22;
    localparam int unsigned CYC_W = 16;

    localparam logic [OFF_W-1:0] OFF_CTRL    = 22'h24;
    localparam logic [OFF_W-1:0] OFF_ADDR_LO = 22'h28;
    localparam logic [OFF_W-1:0] OFF_ADDR_HI = 22'h2C;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_BRESP = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_B = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    // Address/data of beat 0..2: init address low, high, then the control word.
    function automatic beat_t beat_payload(input logic [1:0]       beat,
                                           input logic [PID_W-1:0] pid,
                                           input logic [63:0]      job_addr,
                                           input logic [7:0]       ctrl);
        beat_t p;
        p = '0;
        case (beat)
            2'd0: begin
                p.addr = {1'b0, pid, OFF_ADDR_LO};
                p.data = job_addr[31:0];
            end
            2'd1: begin
                p.addr = {1'b0, pid, OFF_ADDR_HI};
                p.data = job_addr[63:32];
            end
            default: begin
                p.addr = {1'b0, pid, OFF_CTRL};
                p.data = {16'h0000, ctrl, 8'h00};
            end
        endcase
        return p;
    endfunction

endpackage

// File: rtl/mp_axil_wr_beat.sv
// One AXI-Lite write: AW and W raised together, each dropped after its own
// handshake, then B accepted once both have gone.
module mp_axil_wr_beat #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [ADDR_WIDTH-1:0] awaddr_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    output logic [DATA_WIDTH-1:0] wdata_o,
    input  logic                  bvalid_i,
    output logic                  bready_o,
    output logic                  aw_w_done_c,
    output logic                  b_done_c
);

    logic                  active_q, active_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  bready_q, bready_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  aw_acc_c, w_acc_c;

    always_comb begin
        active_d  = active_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        bready_d  = bready_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;

        aw_acc_c    = awvalid_q & awready_i;
        w_acc_c     = wvalid_q & wready_i;
        aw_w_done_c = active_q & ~bready_q & (aw_done_q | aw_acc_c) & (w_done_q | w_acc_c);
        b_done_c    = bready_q & bvalid_i;

        if (start_i && !active_q) begin
            active_d  = 1'b1;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            awaddr_d  = addr_i;
            wdata_d   = data_i;
        end
        if (aw_acc_c) begin
            awvalid_d = 1'b0;
            aw_done_d = 1'b1;
        end
        if (w_acc_c) begin
            wvalid_d = 1'b0;
            w_done_d = 1'b1;
        end
        if (aw_w_done_c) begin
            bready_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end
        if (b_done_c) begin
            bready_d = 1'b0;
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
        end else begin
            active_q  <= active_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bready_q  <= bready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign awvalid_o = awvalid_q;
    assign awaddr_o  = awaddr_q;
    assign wvalid_o  = wvalid_q;
    assign wdata_o   = wdata_q;
    assign bready_o  = bready_q;

endmodule

// File: rtl/mp_dispatch_master.sv
// Dispatches a job as three AXI-Lite register writes (addr lo, addr hi, ctrl)
// into the per-process window selected by pid.
module mp_dispatch_master
    import mp_dispatch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid_i,
    output logic                  job_ready_o,
    input  logic [PID_W-1:0]      job_pid_i,
    input  logic [63:0]           job_addr_i,
    input  logic [7:0]            job_ctrl_i,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    input  logic [1:0]            m_axi_bresp,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [1:0]            err_o,
    output logic [CYC_W-1:0]      job_cycles_o
);

    state_e           state_q, state_d;
    logic [1:0]       beat_q, beat_d;
    logic [PID_W-1:0] pid_q, pid_d;
    logic [63:0]      addr_q, addr_d;
    logic [7:0]       ctrl_q, ctrl_d;
    logic [CYC_W-1:0] cnt_q, cnt_d;
    logic [CYC_W-1:0] job_cycles_q, job_cycles_d;
    logic [1:0]       err_q, err_d;
    logic             job_ready_q, job_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept_c, start_c, aw_w_done_c, b_done_c;
    beat_t            payload_c;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        pid_d        = pid_q;
        addr_d       = addr_q;
        ctrl_d       = ctrl_q;
        cnt_d        = cnt_q;
        job_cycles_d = job_cycles_q;
        err_d        = err_q;

        accept_c  = (state_q == ST_IDLE) && job_ready_q && job_valid_i;
        start_c   = (state_q == ST_ISSUE);
        payload_c = beat_payload(beat_q, pid_q, addr_q, ctrl_q);

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_ISSUE;
                    beat_d  = 2'd0;
                    pid_d   = job_pid_i;
                    addr_d  = job_addr_i;
                    ctrl_d  = job_ctrl_i;
                    cnt_d   = '0;
                    err_d   = ERR_OK;
                end
            end
            ST_ISSUE: begin
                if (aw_w_done_c) state_d = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                if (b_done_c) begin
                    // A failed write aborts the remaining beats of the job.
                    if (m_axi_bresp != 2'b00) begin
                        state_d = ST_DONE;
                        err_d   = ERR_BRESP;
                    end else if (beat_q == 2'd2) begin
                        state_d = ST_DONE;
                        err_d   = ERR_OK;
                    end else begin
                        state_d = ST_ISSUE;
                        beat_d  = beat_q + 2'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if ((state_q == ST_ISSUE || state_q == ST_WAIT_B) && cnt_q != '1) begin
            cnt_d = cnt_q + CYC_W'(1);
        end
        if (state_q == ST_WAIT_B && state_d == ST_DONE) job_cycles_d = cnt_d;

        job_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            beat_q       <= 2'd0;
            pid_q        <= '0;
            addr_q       <= '0;
            ctrl_q       <= '0;
            cnt_q        <= '0;
            job_cycles_q <= '0;
            err_q        <= ERR_OK;
            job_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            pid_q        <= pid_d;
            addr_q       <= addr_d;
            ctrl_q       <= ctrl_d;
            cnt_q        <= cnt_d;
            job_cycles_q <= job_cycles_d;
            err_q        <= err_d;
            job_ready_q  <= job_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    mp_axil_wr_beat #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_beat (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_c),
        .addr_i      (ADDR_WIDTH'(payload_c.addr)),
        .data_i      (DATA_WIDTH'(payload_c.data)),
        .awvalid_o   (m_axi_awvalid),
        .awready_i   (m_axi_awready),
        .awaddr_o    (m_axi_awaddr),
        .wvalid_o    (m_axi_wvalid),
        .wready_i    (m_axi_wready),
        .wdata_o     (m_axi_wdata),
        .bvalid_i    (m_axi_bvalid),
        .bready_o    (m_axi_bready),
        .aw_w_done_c (aw_w_done_c),
        .b_done_c    (b_done_c)
    );

    assign m_axi_awprot = 3'b000;
    assign m_axi_wstrb  = 4'hF;
    assign job_ready_o  = job_ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign job_cycles_o = job_cycles_q;

endmodule

// File: tb/tb_mp_dispatch_master.sv
// Scoreboard bench for mp_dispatch_master: randomized slave timing and jobs,
// expected writes and job results computed from the register-write rules.
module tb_mp_dispatch_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_valid;
    logic        job_ready;
    logic [8:0]  job_pid;
    logic [63:0] job_addr;
    logic [7:0]  job_ctrl;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] awaddr, wdata;
    logic [2:0]  awprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, err;
    logic        busy, done;
    logic [15:0] job_cycles;

    always #5 clk = ~clk;

    mp_dispatch_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .job_valid_i(job_valid), .job_ready_o(job_ready), .job_pid_i(job_pid),
        .job_addr_i(job_addr), .job_ctrl_i(job_ctrl),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
        .m_axi_awprot(awprot), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready), .m_axi_bresp(bresp), .busy_o(busy), .done_o(done),
        .err_o(err), .job_cycles_o(job_cycles)
    );

    // Scoreboard state
    logic [63:0] exp_wr_q[$];
    int          exp_nwr_q[$];
    logic [1:0]  exp_err_q[$];
    logic [1:0]  bresp_q[$];
    logic [31:0] aw_fifo[$];
    logic [31:0] w_fifo[$];
    int n_tests = 0, n_fail = 0;
    int cycle = 0, acc_cycle = 0, last_done_cycle = 0;
    int aw_cnt = 0, w_cnt = 0, b_hs_cnt = 0, wr_seen = 0;
    logic [1:0] last_err = 2'b00;

    // Slave behaviour knobs
    int ready_mode = 0, aw_delay = 0, w_delay = 0, b_delay_fixed = 0, b_long = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endfunction

    // Reference model: a job is the ordered list of register writes it must produce.
    task automatic push_exp(input logic [8:0] pid, input logic [63:0] addr, input logic [7:0] ctrl,
                            input int err_beat, input logic [1:0] bad_resp);
        logic [31:0] a[3];
        logic [31:0] d[3];
        int n;
        a[0] = {1'b0, pid, 22'h28}; d[0] = addr[31:0];
        a[1] = {1'b0, pid, 22'h2C}; d[1] = addr[63:32];
        a[2] = {1'b0, pid, 22'h24}; d[2] = {16'h0, ctrl, 8'h00};
        n = (err_beat < 0) ? 3 : err_beat + 1;
        for (int i = 0; i < n; i++) begin
            exp_wr_q.push_back({a[i], d[i]});
            bresp_q.push_back((i == err_beat) ? bad_resp : 2'b00);
        end
        exp_nwr_q.push_back(n);
        exp_err_q.push_back((err_beat < 0) ? 2'b00 : 2'b01);
    endtask

    task automatic drive_job(input logic [8:0] pid, input logic [63:0] addr, input logic [7:0] ctrl);
        @(posedge clk); #1;
        job_valid = 1'b1;
        job_pid   = pid;
        job_addr  = addr;
        job_ctrl  = ctrl;
    endtask

    task automatic wait_accept(input bit hold);
        bit got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (job_ready) begin got = 1; break; end
        end
        if (!got) fail("accept_timeout");
        @(posedge clk); #1;
        if (!hold) job_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        bit got = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin got = 1; break; end
        end
        if (!got) fail("done_timeout");
        @(posedge clk);
    endtask

    task automatic run_job(input logic [8:0] pid, input logic [63:0] addr, input logic [7:0] ctrl,
                           input int err_beat, input logic [1:0] bad_resp, input int bound);
        push_exp(pid, addr, ctrl, err_beat, bad_resp);
        drive_job(pid, addr, ctrl);
        wait_accept(1'b0);
        wait_done(bound);
    endtask

    // AXI-Lite slave: readies per mode, B issued after both AW and W of a beat
    int aw_wait = 0, w_wait = 0, b_started = 0, b_seen = 0, b_wait = 0, cur_delay = 0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
            aw_wait = 0; w_wait = 0; b_started = 0; b_seen = 0; b_wait = 0;
        end else begin
            aw_wait = awvalid ? aw_wait + 1 : 0;
            w_wait  = wvalid ? w_wait + 1 : 0;
            case (ready_mode)
                0: begin awready = 1'b1; wready = 1'b1; end
                1: begin awready = 1'($urandom_range(0, 1)); wready = 1'($urandom_range(0, 1)); end
                default: begin awready = (aw_wait > aw_delay); wready = (w_wait > w_delay); end
            endcase
            if (bvalid && b_hs_cnt != b_seen) begin
                bvalid = 1'b0;
                b_seen = b_hs_cnt;
            end
            if (!bvalid && b_started < aw_cnt && b_started < w_cnt) begin
                if (b_wait == 0) begin
                    if (b_long > 0) begin cur_delay = b_long; b_long = 0; end
                    else cur_delay = (b_delay_fixed >= 0) ? b_delay_fixed : int'($urandom_range(0, 4));
                end
                if (b_wait >= cur_delay) begin
                    bvalid = 1'b1;
                    bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
                    b_started++;
                    b_wait = 0;
                end else begin
                    b_wait++;
                end
            end
        end
    end

    // Monitor: protocol rules plus scoreboard pops, sampled mid-cycle
    logic        aw_pend = 0, w_pend = 0, aw_prev = 0, w_prev = 0, done_prev = 0;
    logic [31:0] aw_pend_addr = 0, w_pend_data = 0;
    always @(negedge clk) begin
        cycle++;
        if (rst) begin
            aw_cnt = 0; w_cnt = 0; b_hs_cnt = 0; wr_seen = 0;
            aw_fifo.delete(); w_fifo.delete();
            aw_pend = 0; w_pend = 0; aw_prev = 0; w_prev = 0; done_prev = 0;
            last_err = 2'b00;
        end else begin
            if (aw_pend) check("aw_held_until_handshake", 64'({awvalid, awaddr}), 64'({1'b1, aw_pend_addr}));
            if (w_pend)  check("w_held_until_handshake", 64'({wvalid, wdata}), 64'({1'b1, w_pend_data}));
            if (awvalid && !aw_prev) check("aw_w_rise_together", 64'({wvalid, w_prev}), 64'(2'b10));
            if (bready) begin
                check("bready_after_aw", 64'(aw_cnt - b_hs_cnt), 64'd1);
                check("bready_after_w", 64'(w_cnt - b_hs_cnt), 64'd1);
            end
            if (awvalid && awready) begin
                check("awprot", 64'(awprot), 64'd0);
                aw_fifo.push_back(awaddr);
                aw_cnt++;
            end
            if (wvalid && wready) begin
                check("wstrb", 64'(wstrb), 64'hF);
                w_fifo.push_back(wdata);
                w_cnt++;
            end
            while (aw_fifo.size() > 0 && w_fifo.size() > 0) begin
                logic [31:0] a, d;
                a = aw_fifo.pop_front();
                d = w_fifo.pop_front();
                wr_seen++;
                if (exp_wr_q.size() == 0) begin
                    fail("unexpected_write");
                    $display("  write addr %h data %h", a, d);
                end else begin
                    check("write_addr_data", {a, d}, exp_wr_q.pop_front());
                end
            end
            if (bvalid && bready) b_hs_cnt++;
            if (busy) check("ready_low_while_busy", 64'(job_ready), 64'd0);
            if (job_ready) check("err_held_in_idle", 64'(err), 64'(last_err));
            if (job_valid && job_ready) acc_cycle = cycle;
            if (done) begin
                int dc;
                check("done_single_pulse", 64'(done_prev), 64'd0);
                check("busy_in_done", 64'(busy), 64'd1);
                if (exp_err_q.size() == 0) fail("unexpected_done");
                else check("job_err", 64'(err), 64'(exp_err_q.pop_front()));
                if (exp_nwr_q.size() > 0) check("job_write_count", 64'(wr_seen), 64'(exp_nwr_q.pop_front()));
                dc = cycle - acc_cycle - 1;
                check("job_cycles", 64'(job_cycles), 64'((dc > 65535) ? 65535 : dc));
                wr_seen = 0;
                last_err = err;
                last_done_cycle = cycle;
            end
            aw_pend = awvalid && !awready; aw_pend_addr = awaddr;
            w_pend  = wvalid && !wready;   w_pend_data  = wdata;
            aw_prev = awvalid; w_prev = wvalid; done_prev = done;
        end
    end

    initial begin
        bit got;
        job_valid = 1'b0; job_pid = '0; job_addr = '0; job_ctrl = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_job_ready", 64'(job_ready), 64'd0);
        check("rst_valids_bready", 64'({awvalid, wvalid, bready}), 64'd0);
        check("rst_busy_done", 64'({busy, done}), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_job_cycles", 64'(job_cycles), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("ready_after_reset", 64'(job_ready), 64'd1);

        // Directed example job, readies tied high
        ready_mode = 0; b_delay_fixed = 0;
        run_job(9'h005, 64'h0000_0001_2345_6780, 8'hA5, -1, 2'b00, 200);

        // Skewed AW/W acceptance in both orders
        ready_mode = 2; aw_delay = 3; w_delay = 0;
        run_job(9'h1A3, 64'hDEAD_BEEF_0BAD_F00D, 8'h3C, -1, 2'b00, 300);
        aw_delay = 0; w_delay = 3;
        run_job(9'h0F0, 64'h1111_2222_3333_4444, 8'h81, -1, 2'b00, 300);

        // SLVERR on the second beat aborts the control write
        ready_mode = 0;
        run_job(9'h042, 64'hCAFE_0000_BEEF_0001, 8'h7E, 1, 2'b10, 300);

        // First B withheld past the cycle counter range
        b_long = 70000;
        run_job(9'h111, 64'h0000_0000_FFFF_0000, 8'h01, -1, 2'b00, 80000);

        // Reset during WAIT_B of the first beat
        b_delay_fixed = 30;
        push_exp(9'h0AA, 64'h5555_AAAA_5555_AAAA, 8'h99, -1, 2'b00);
        drive_job(9'h0AA, 64'h5555_AAAA_5555_AAAA, 8'h99);
        wait_accept(1'b0);
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bready) begin got = 1; break; end
        end
        if (!got) fail("bready_timeout");
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("midjob_rst_valids", 64'({awvalid, wvalid, bready}), 64'd0);
        check("midjob_rst_busy_ready", 64'({busy, done, job_ready}), 64'd0);
        exp_wr_q.delete(); exp_nwr_q.delete(); exp_err_q.delete(); bresp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("ready_after_midjob_rst", 64'(job_ready), 64'd1);
        b_delay_fixed = -1;
        run_job(9'h0AB, 64'h0123_4567_89AB_CDEF, 8'h5A, -1, 2'b00, 300);

        // Back-to-back jobs with job_valid held high
        push_exp(9'h100, 64'hAAAA_0000_0000_BBBB, 8'h10, -1, 2'b00);
        drive_job(9'h100, 64'hAAAA_0000_0000_BBBB, 8'h10);
        wait_accept(1'b1);
        job_pid = 9'h101; job_addr = 64'hCCCC_1111_2222_DDDD; job_ctrl = 8'h20;
        push_exp(9'h101, 64'hCCCC_1111_2222_DDDD, 8'h20, -1, 2'b00);
        wait_accept(1'b0);
        check("b2b_accept_after_done", 64'(acc_cycle), 64'(last_done_cycle + 1));
        wait_done(300);

        // Randomized jobs and slave timing
        for (int j = 0; j < 14; j++) begin
            int eb;
            ready_mode = $urandom_range(0, 2);
            aw_delay   = $urandom_range(0, 3);
            w_delay    = $urandom_range(0, 3);
            eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            run_job(9'($urandom), {$urandom, $urandom}, 8'($urandom), eb,
                    2'($urandom_range(1, 3)), 400);
        end

        repeat (5) @(posedge clk);
        check("queues_drained", 64'(exp_wr_q.size() + exp_err_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mp_dispatch_master.md
MP_DISPATCH_MASTER -- requirements
Module: mp_dispatch_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI-Lite data width; only 32 is supported.
REQ-003 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, reset); one clock, reset synchronous active-high.
REQ-004 SHALL have job_valid_i (in, 1), job_ready_o (out, 1), job_pid_i (in, 9, process id), job_addr_i (in, 64, init address), job_ctrl_i (in, 8, control byte).
REQ-005 SHALL have m_axi_awvalid (out, 1), m_axi_awready (in, 1), m_axi_awaddr (out, ADDR_WIDTH), m_axi_awprot (out, 3, constant 0).
REQ-006 SHALL have m_axi_wvalid (out, 1), m_axi_wready (in, 1), m_axi_wdata (out, 32), m_axi_wstrb (out, 4, constant 4'hF).
REQ-007 SHALL have m_axi_bvalid (in, 1), m_axi_bready (out, 1), m_axi_bresp (in, 2).
REQ-008 SHALL have busy_o (out, 1), done_o (out, 1, one-cycle pulse), err_o (out, 2, job status), job_cycles_o (out, 16, cycle count of the last job).

Function
REQ-009 SHALL accept a job on job_valid_i & job_ready_o and register pid, addr and ctrl in that cycle; job_ready_o SHALL be 1 only in IDLE.
REQ-010 SHALL issue three AXI-Lite writes per job, strictly in order: offset 0x28 data addr[31:0], then 0x2C data addr[63:32], then 0x24 data {16'h0, ctrl, 8'h00}.
REQ-011 SHALL form every awaddr as bit31=0, [30:22]=pid, [21:0]=offset.
REQ-012 SHALL use the FSM states IDLE -> ISSUE -> WAIT_B -> (ISSUE for the next beat | DONE) -> IDLE, with a 2-bit beat index 0..2.
REQ-013 SHALL raise awvalid and wvalid together on the cycle after entering ISSUE, and SHALL drop each independently on the cycle after its own handshake.
REQ-014 SHALL never make any valid depend combinationally on a ready, and SHALL never drop a valid before its handshake.
REQ-015 SHALL handle AW and W accepted in the same cycle or in either order; it SHALL enter WAIT_B only once both have been accepted.
REQ-016 SHALL assert bready only in WAIT_B, and SHALL complete the beat on bvalid & bready.
REQ-017 SHALL, on bresp != 2'b00, skip the remaining beats, go to DONE and report err_o=2'b01.
REQ-018 SHALL, when all three beats return OKAY, report err_o=2'b00.
REQ-019 SHALL pulse done_o for exactly one cycle in DONE, return to IDLE on the next cycle, and hold err_o until the next job is accepted.
REQ-020 SHALL clear job_cycles_o's working counter when a job is accepted and increment it every cycle until DONE, saturating at 16'hFFFF; the value SHALL be latched at DONE.
REQ-021 SHALL hold busy_o=1 from the cycle after acceptance through DONE inclusive.
REQ-022 SHALL ignore job_valid_i while busy; a job held valid SHALL be accepted in the IDLE cycle after DONE.

Reset
REQ-023 SHALL, while rst=1 at a clock edge, set the FSM to IDLE and set awvalid, wvalid, bready, done_o, busy_o and job_cycles_o to 0, err_o to 2'b00, and job_ready_o to 0.
REQ-024 SHALL abandon any in-flight transaction when reset is asserted mid-job; the interconnect is reset by the same rst.
REQ-025 SHALL assert job_ready_o on the first cycle after rst deasserts.

Structure
REQ-026 SHALL define in package mp_dispatch_pkg the offsets (0x24, 0x28, 0x2C), the error codes (OK=00, BRESP=01), and the FSM state enum.
REQ-027 SHALL implement the single-write AW/W/B handshake as sub-module mp_axil_wr_beat, instantiated once and sequenced by the top-level FSM.

Verification
REQ-028 SHALL cover this case: pid=9'h005, addr=64'h0000_0001_2345_6780, ctrl=8'hA5, all readies tied 1 -> writes are 0x01400028/0x23456780, 0x0140002C/0x00000001, 0x01400024/0x0000A500; done_o pulses; err_o=00.
REQ-029 SHALL cover this case: awready delayed 3 cycles and wready 0 cycles, then the reverse -> each valid is held until its own handshake, no duplicate beats, B is waited on only after both handshakes.
REQ-030 SHALL cover this case: the second beat returns bresp=2'b10 -> the 0x24 write is never issued, err_o=01, done_o pulses once.
REQ-031 SHALL cover this case: bvalid is withheld for 70000 cycles -> job_cycles_o=16'hFFFF at done.
REQ-032 SHALL cover this case: rst is pulsed during WAIT_B of the first beat -> all valids are 0 the cycle after, job_ready_o=1 after release, and a new job runs cleanly.
REQ-033 SHALL cover this case: back-to-back jobs with job_valid_i held high -> the second job is accepted in the IDLE cycle after the first done_o.
